seq_div_sequencer: RTL and testbench

- Request/response front-end for the sequential subtract-and-shift divider; the divider is an unsigned core with a start/finish interface.
- Accepts operand pairs over a valid/ready handshake and optionally converts signed operands to magnitudes.
- Issues a one-cycle start pulse, holds the operands stable, and waits for finish.
- Applies the sign fix-up and presents quotient/remainder on a valid/ready response port, held until consumed.

---
 rtl/seq_div_sequencer.sv | 123 ++++++++++++
 tb/tb_seq_div_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_sequencer.sv
// Request/response sequencer around an unsigned subtract-and-shift divider, with signed fix-up.
// Optional macro SEQ_DIV_ZERO_BYPASS_EN: divide-by-zero requests skip the divider and raise resp_dz_o.
module seq_div_sequencer #(
    parameter int unsigned WidthA = 32,
    parameter int unsigned WidthB = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [WidthA-1:0] req_a_i,
    input  logic [WidthB-1:0] req_b_i,
    input  logic              req_signed_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [WidthA-1:0] resp_q_o,
    output logic [WidthB-1:0] resp_r_o,
`ifdef SEQ_DIV_ZERO_BYPASS_EN
    output logic              resp_dz_o,
`endif
    output logic              div_start_o,
    output logic [WidthA-1:0] div_a_o,
    output logic [WidthB-1:0] div_b_o,
    input  logic              div_finish_i,
    input  logic [WidthA-1:0] div_q_i,
    input  logic [WidthB-1:0] div_r_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e            state_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic              req_fire_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic [WidthA-1:0] a_mag_c;
    logic [WidthB-1:0] b_mag_c;
    logic [WidthA-1:0] q_fix_c;
    logic [WidthB-1:0] r_fix_c;

    assign req_fire_c = req_valid_i & req_ready_o;
    assign a_neg_c    = req_signed_i & req_a_i[WidthA-1];
    assign b_neg_c    = req_signed_i & req_b_i[WidthB-1];

    // Two's-complement negation maps the most negative value onto 2^(W-1), its true magnitude.
    assign a_mag_c = a_neg_c ? (~req_a_i + WidthA'(1)) : req_a_i;
    assign b_mag_c = b_neg_c ? (~req_b_i + WidthB'(1)) : req_b_i;
    assign q_fix_c = neg_q_q ? (~div_q_i + WidthA'(1)) : div_q_i;
    assign r_fix_c = neg_r_q ? (~div_r_i + WidthB'(1)) : div_r_i;

    // Operation sequencer: accept, start the divider, wait for finish, hold the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_q_o     <= '0;
            resp_r_o     <= '0;
            div_start_o  <= 1'b0;
            div_a_o      <= '0;
            div_b_o      <= '0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
`ifdef SEQ_DIV_ZERO_BYPASS_EN
            resp_dz_o    <= 1'b0;
`endif
        end else begin
            div_start_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_fire_c) begin
                        neg_q_q     <= a_neg_c ^ b_neg_c;
                        neg_r_q     <= a_neg_c;
                        req_ready_o <= 1'b0;
`ifdef SEQ_DIV_ZERO_BYPASS_EN
                        if (req_b_i == '0) begin
                            resp_q_o     <= '1;
                            resp_r_o     <= WidthB'(req_a_i);
                            resp_dz_o    <= 1'b1;
                            resp_valid_o <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            div_a_o     <= a_mag_c;
                            div_b_o     <= b_mag_c;
                            div_start_o <= 1'b1;
                            resp_dz_o   <= 1'b0;
                            state_q     <= ISSUE;
                        end
`else
                        div_a_o     <= a_mag_c;
                        div_b_o     <= b_mag_c;
                        div_start_o <= 1'b1;
                        state_q     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (div_finish_i) begin
                        resp_q_o     <= q_fix_c;
                        resp_r_o     <= r_fix_c;
                        resp_valid_o <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_sequencer.sv
// Self-checking bench for seq_div_sequencer with a behavioural multi-cycle divider and a signed-division reference.
// Exercises the SEQ_DIV_ZERO_BYPASS_EN path when that macro is defined.
module tb_seq_div_sequencer;

    localparam int unsigned W   = 32;
    localparam int          LAT = 36;
    localparam int          TMO = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_signed = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_q;
    logic [W-1:0] resp_r;
    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_finish;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;
`ifdef SEQ_DIV_ZERO_BYPASS_EN
    logic         resp_dz;
`endif

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    seq_div_sequencer #(.WidthA(W), .WidthB(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_signed_i (req_signed),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_q_o     (resp_q),
        .resp_r_o     (resp_r),
`ifdef SEQ_DIV_ZERO_BYPASS_EN
        .resp_dz_o    (resp_dz),
`endif
        .div_start_o  (div_start),
        .div_a_o      (div_a),
        .div_b_o      (div_b),
        .div_finish_i (div_finish),
        .div_q_i      (div_q),
        .div_r_i      (div_r)
    );

    // Divider stand-in: busy for W+2 cycles after start, then finish with the unsigned result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 0;
            div_finish <= 1'b1;
            div_q      <= '0;
            div_r      <= '0;
        end else if (div_start) begin
            cnt        <= W + 2;
            div_finish <= 1'b0;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                div_finish <= 1'b1;
                div_q      <= (div_b == '0) ? '1 : div_a / div_b;
                div_r      <= (div_b == '0) ? div_a : div_a % div_b;
            end
        end
    end

    // Reference: exact integer division truncating toward zero, reduced modulo 2^W.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int starts, output bit tmo);
        int n;
        req_a = a; req_b = b; req_signed = s; req_valid = 1'b1; resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < TMO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; starts = 0;
        while (!resp_valid && lat < TMO) begin
            if (div_start) starts++;
            @(posedge clk); #1;
            lat++;
        end
        tmo = (n >= TMO) || !resp_valid;
        q = resp_q; r = resp_r;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, resp_valid, div_start, resp_q, resp_r, div_a, div_b} !== {3'b100, {(4*W){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b st=%b q=%h r=%h a=%h b=%h expected rdy=1 others 0",
                     req_ready, resp_valid, div_start, resp_q, resp_r, div_a, div_b);
        end
    endtask

    task automatic test_unsigned_basic();
        logic [W-1:0] q, r;
        int lat, starts;
        bit tmo;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat, starts, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL udiv_timeout: no response within %0d cycles", TMO); end
        checks++;
        if ({q, r} !== {32'd14, 32'd2}) begin
            errors++; $display("FAIL udiv_100_7: got q=%0d r=%0d expected q=14 r=2", q, r);
        end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL udiv_latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (starts !== 1) begin errors++; $display("FAIL udiv_start_pulse: got %0d cycles expected 1", starts); end
    endtask

    task automatic test_signed_cases();
        logic [W-1:0] ta [4] = '{32'hFFFF_FFF9, 32'd7,        32'h8000_0000, 32'hFFFF_FF9C};
        logic [W-1:0] tb [4] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [W-1:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd14};
        logic [W-1:0] er [4] = '{32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFE};
        logic [W-1:0] q, r;
        int lat, starts;
        bit tmo;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1'b1, q, r, lat, starts, tmo);
            checks++;
            if (tmo || {q, r} !== {eq[i], er[i]}) begin
                errors++;
                $display("FAIL signed_case%0d: got q=%h r=%h tmo=%b expected q=%h r=%h", i, q, r, tmo, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q0, r0, q, r;
        int n, lat, starts;
        bit tmo;
        req_a = 32'd200; req_b = 32'd9; req_signed = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < TMO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_a = 32'd55; req_b = 32'd5;
        n = 0;
        while (!resp_valid && n < TMO) begin @(posedge clk); #1; n++; end
        q0 = resp_q; r0 = resp_r;
        checks++;
        if (!resp_valid || {q0, r0} !== {32'd22, 32'd2}) begin
            errors++; $display("FAIL bp_result: got vld=%b q=%0d r=%0d expected vld=1 q=22 r=2", resp_valid, q0, r0);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({resp_valid, req_ready, div_start, resp_q, resp_r} !== {3'b100, q0, r0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b st=%b q=%h r=%h expected vld=1 rdy=0 st=0 q=%h r=%h",
                         i, resp_valid, req_ready, div_start, resp_q, resp_r, q0, r0);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({resp_valid, req_ready, div_start} !== 3'b010) begin
            errors++; $display("FAIL bp_release: got vld=%b rdy=%b st=%b expected vld=0 rdy=1 st=0", resp_valid, req_ready, div_start);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if ({div_start, div_a, div_b} !== {1'b1, 32'd55, 32'd5}) begin
            errors++; $display("FAIL bp_next_accept: got st=%b a=%0d b=%0d expected st=1 a=55 b=5", div_start, div_a, div_b);
        end
        n = 0;
        while (!resp_valid && n < TMO) begin @(posedge clk); #1; n++; end
        checks++;
        if (!resp_valid || {resp_q, resp_r} !== {32'd11, 32'd0}) begin
            errors++; $display("FAIL bp_next_result: got vld=%b q=%0d r=%0d expected vld=1 q=11 r=0", resp_valid, resp_q, resp_r);
        end
        @(posedge clk); #1;
        lat = 0; starts = 0; tmo = 1'b0; q = '0; r = '0;
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] q, r;
        int n, lat, starts;
        bit tmo;
        req_a = 32'd1000; req_b = 32'd3; req_signed = 1'b0; req_valid = 1'b1; resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < TMO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, div_start, resp_q, resp_r, div_a, div_b} !== {3'b100, {(4*W){1'b0}}}) begin
            errors++;
            $display("FAIL midop_reset: got rdy=%b vld=%b st=%b q=%h r=%h a=%h b=%h expected rdy=1 others 0",
                     req_ready, resp_valid, div_start, resp_q, resp_r, div_a, div_b);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL midop_release: got rdy=%b vld=%b expected rdy=1 vld=0", req_ready, resp_valid);
        end
        do_op(32'd9, 32'd3, 1'b0, q, r, lat, starts, tmo);
        checks++;
        if (tmo || {q, r} !== {32'd3, 32'd0}) begin
            errors++; $display("FAIL midop_after_9_3: got q=%0d r=%0d tmo=%b expected q=3 r=0", q, r, tmo);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        bit s;
        int lat, starts;
        bit tmo;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = W'($urandom_range(1, 20));
            if (s && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if (b == '0) b = 32'd1;
            model(a, b, s, eq, er);
            do_op(a, b, s, q, r, lat, starts, tmo);
            checks++;
            if (tmo || {q, r} !== {eq, er} || lat !== LAT || starts !== 1) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h s=%b got q=%h r=%h lat=%0d starts=%0d expected q=%h r=%h lat=%0d starts=1",
                         i, a, b, s, q, r, lat, starts, eq, er, LAT);
            end
        end
    endtask

`ifdef SEQ_DIV_ZERO_BYPASS_EN
    task automatic test_zero_bypass();
        int n, starts;
        req_a = 32'h1234; req_b = '0; req_signed = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < TMO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_dz, div_start, resp_q, resp_r} !== {3'b110, 32'hFFFF_FFFF, 32'h1234}) begin
            errors++;
            $display("FAIL dz_bypass: got vld=%b dz=%b st=%b q=%h r=%h expected vld=1 dz=1 st=0 q=ffffffff r=00001234",
                     resp_valid, resp_dz, div_start, resp_q, resp_r);
        end
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            if (div_start) starts++;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (starts !== 0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL dz_release: got starts=%0d rdy=%b vld=%b expected 0 1 0", starts, req_ready, resp_valid);
        end
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_unsigned_basic();
        test_signed_cases();
        test_backpressure();
        test_reset_mid_op();
`ifdef SEQ_DIV_ZERO_BYPASS_EN
        test_zero_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
